result_packetizer: RTL and testbench
====================================

RESULT_PACKETIZER -- requirements
Module: result_packetizer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of miner result channels, legal range 1..16.
REQ-002 SHALL have parameter NONCE_W, default 64, nonce width in bits, a multiple of 8 in the range 8..256.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, the first byte of every frame.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port res_valid  in  NUM_CH  per-channel result available.
REQ-007 SHALL have port res_found  in  NUM_CH  per-channel nonce-found flag.
REQ-008 SHALL have port res_nonce  in  NUM_CH*NONCE_W  channel i occupies bits [i*NONCE_W +: NONCE_W].
REQ-009 SHALL have port res_ready  out  NUM_CH  per-channel accept; transfer occurs when valid and ready are both high.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port send  out  1  one-cycle byte-launch strobe to the UART.
REQ-012 SHALL have port tx_data  out  8  byte to transmit, valid while send is high.

Function
REQ-013 SHALL emit a frame in this order: SYNC_BYTE; header {found, 3'b000, ch[3:0]}; then, only if found, NONCE_W/8 nonce bytes, least-significant byte first.
REQ-014 SHALL use states S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO.
- S_IDLE -> S_SEND on capture.
- S_SEND -> S_WAIT_HI when tx_busy=0.
- S_WAIT_HI -> S_WAIT_LO when tx_busy=1.
- S_WAIT_LO -> S_SEND when another byte remains, otherwise -> S_IDLE.
REQ-015 SHALL, in S_IDLE, grant one channel by round-robin among asserted res_valid, and drive res_ready one-hot to that channel only; res_ready SHALL be all-zero in every other state.
REQ-016 SHALL start the round-robin search at the channel one above the last granted channel, wrapping from NUM_CH-1 to 0; after reset the search SHALL start at channel 0.
REQ-017 SHALL, on the capture cycle, register the granted channel's found flag, nonce and channel index; later changes on the inputs SHALL NOT affect the frame in flight.
REQ-018 SHALL produce send and tx_data from registers: send is high for exactly one cycle per byte, in the cycle after S_SEND is entered with tx_busy=0.
REQ-019 SHALL hold tx_data stable from the send cycle until the next send, and drive 8'h00 when idle.
REQ-020 SHALL count bytes with a counter sized to hold NONCE_W/8+3 without wrap.
REQ-021 SHALL take minimum frame latency from capture to first send of 2 cycles.
REQ-022 SHALL allow back-to-back frames: a new capture may occur on the first S_IDLE cycle after a frame ends.
REQ-023 SHALL NOT emit send while tx_busy=1; it SHALL wait in S_WAIT_HI indefinitely if tx_busy never rises.
REQ-024 SHALL, when several channels are valid simultaneously, serve them one frame each, in round-robin order.

Reset
REQ-025 SHALL, on rst asserted: state=S_IDLE; send=0; tx_data=8'h00; res_ready=0 while rst is high; RR pointer=0; byte counter and captured registers=0.
REQ-026 SHALL abort any frame in progress on reset mid-frame, with no further send; the aborted result is lost.

Configuration
REQ-027 SHALL, with RESULT_PKT_CSUM_EN defined, append one trailing byte to every frame: the XOR of the header byte and all nonce bytes sent; SYNC_BYTE SHALL be excluded from the XOR.
REQ-028 SHALL, without RESULT_PKT_CSUM_EN, end the frame after the last header or nonce byte and synthesise no checksum logic.

Structure
REQ-029 SHALL place the state enum, the header bit-field positions and the default SYNC_BYTE in shared package proto_pkg.
REQ-030 SHALL implement round-robin grant generation in sub-module rr_arbiter (parameter N; inputs req and advance; output one-hot grant).

Verification
REQ-031 SHALL cover: ch0 valid, found=1, nonce=64'h0123456789ABCDEF, UART model busy 10 cycles per byte -> bytes A5,80,EF,CD,AB,89,67,45,23,01.
REQ-032 SHALL cover: ch2 valid, found=0 -> bytes A5,02 only; res_ready[2] high exactly one cycle.
REQ-033 SHALL cover: ch1 and ch3 valid together, last grant 0 -> ch1 frame then ch3 frame; then ch0 and ch3 valid -> ch0 first.
REQ-034 SHALL cover: rst pulsed during the third nonce byte -> send stays 0 afterward; state and outputs take their reset values; the next valid is served normally.
REQ-035 SHALL cover: RESULT_PKT_CSUM_EN defined, found=1, nonce=64'h1 -> trailing byte 8'h81.
REQ-036 SHALL cover: tx_busy held high at capture for 50 cycles -> no send until tx_busy=0; send is never asserted while tx_busy=1.

Source files
------------

// File: rtl/proto_pkg.sv
// Shared framing definitions for the result packetizer: FSM states,
// header bit-field layout and the default sync byte.
package proto_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int HDR_FOUND_BIT = 7;
  localparam int HDR_CH_LSB = 0;
  localparam int HDR_CH_W = 4;

  function automatic logic [7:0] make_hdr(
    input logic                found,
    input logic [HDR_CH_W-1:0] ch
  );
    logic [7:0] h;
    h = '0;
    h[HDR_FOUND_BIT] = found;
    h[HDR_CH_LSB +: HDR_CH_W] = ch;
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one above the
// last channel granted on advance; starts at 0 after reset.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          hit;

  always_comb begin : search
    int j;
    grant = '0;
    gidx  = '0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!hit && req[PW'(j)]) begin
        hit = 1'b1;
        grant[PW'(j)] = 1'b1;
        gidx = PW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && hit) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/result_packetizer.sv
// Frames miner results as SYNC, header, optional LSB-first nonce bytes
// for a UART; RESULT_PKT_CSUM_EN appends an XOR checksum byte.
module result_packetizer
  import proto_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         NONCE_W   = 64,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         res_valid,
  input  logic [NUM_CH-1:0]         res_found,
  input  logic [NUM_CH*NONCE_W-1:0] res_nonce,
  output logic [NUM_CH-1:0]         res_ready,
  input  logic                      tx_busy,
  output logic                      send,
  output logic [7:0]                tx_data
);

  localparam int NB = NONCE_W / 8;
`ifdef RESULT_PKT_CSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif
  localparam int CW = $clog2(NB + 4);

  state_t               state, state_d;
  logic [NUM_CH-1:0]    grant;
  logic                 capture;
  logic                 launch;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        total;
  logic [CW-1:0]        idx;
  logic                 found_q;
  logic [HDR_CH_W-1:0]  ch_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic                 send_q;
  logic [7:0]           tx_data_q;
  logic [HDR_CH_W-1:0]  gidx;
  logic                 fsel;
  logic [NONCE_W-1:0]   nsel;
  logic [7:0]           nbyte;
  logic [7:0]           cur_byte;
  logic                 is_nonce;
`ifdef RESULT_PKT_CSUM_EN
  logic [7:0]           csum_q;
`endif

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (res_valid),
    .advance (capture),
    .grant   (grant)
  );

  assign capture   = (state == S_IDLE) && (|grant);
  assign res_ready = (state == S_IDLE && !rst) ? grant : '0;
  assign send      = send_q;
  assign tx_data   = tx_data_q;
  assign total     = found_q ? CW'(NB + 2 + XB) : CW'(2 + XB);
  assign idx       = cnt - CW'(2);
  assign is_nonce  = found_q && cnt >= CW'(2) && cnt < CW'(NB + 2);

  always_comb begin
    gidx = '0;
    fsel = 1'b0;
    nsel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gidx = HDR_CH_W'(i);
        fsel = res_found[i];
        nsel = res_nonce[i*NONCE_W +: NONCE_W];
      end
    end
  end

  always_comb begin
    nbyte = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (idx == CW'(k)) nbyte = nonce_q[k*8 +: 8];
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    unique case (1'b1)
      cnt == CW'(0): cur_byte = SYNC_BYTE;
      cnt == CW'(1): cur_byte = make_hdr(found_q, ch_q);
      is_nonce:      cur_byte = nbyte;
`ifdef RESULT_PKT_CSUM_EN
      default:       cur_byte = csum_q;
`else
      default:       cur_byte = 8'h00;
`endif
    endcase
  end

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    case (state)
      S_IDLE:    if (capture) state_d = S_SEND;
      S_SEND: begin
        if (!tx_busy) begin
          state_d = S_WAIT_HI;
          launch  = 1'b1;
        end
      end
      S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!tx_busy) state_d = (cnt != total) ? S_SEND : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      found_q   <= 1'b0;
      ch_q      <= '0;
      nonce_q   <= '0;
      send_q    <= 1'b0;
      tx_data_q <= 8'h00;
`ifdef RESULT_PKT_CSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state  <= state_d;
      send_q <= launch;
      if (capture) begin
        found_q <= fsel;
        ch_q    <= gidx;
        nonce_q <= nsel;
        cnt     <= '0;
`ifdef RESULT_PKT_CSUM_EN
        csum_q  <= 8'h00;
`endif
      end
      if (launch) begin
        tx_data_q <= cur_byte;
        cnt       <= cnt + CW'(1);
`ifdef RESULT_PKT_CSUM_EN
        // sync byte is outside the checksum
        if (cnt != CW'(0)) csum_q <= csum_q ^ cur_byte;
`endif
      end
      if (state == S_WAIT_LO && state_d == S_IDLE) tx_data_q <= 8'h00;
    end
  end

endmodule

// File: tb/tb_result_packetizer.sv
// Directed bench for result_packetizer; also valid with
// RESULT_PKT_CSUM_EN defined (expects the trailing XOR byte).
module tb_result_packetizer;

`ifdef RESULT_PKT_CSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   res_valid;
  logic [3:0]   res_found;
  logic [255:0] res_nonce;
  logic [3:0]   res_ready;
  logic         tx_busy;
  logic         send;
  logic [7:0]   tx_data;

  logic         hold_busy;
  int           bcnt;
  logic [7:0]   q[$];
  int           gq[$];
  int           rdy_cnt[4];
  int           viol;
  logic         prev_send;
  int           n_assert;
  int           n_fail;

  typedef struct {
    int          ch;
    bit          found;
    logic [63:0] nonce;
    int          n;
    logic [79:0] bytes;
  } vec_t;

  vec_t vt[4];

  always #5 clk = ~clk;

  result_packetizer dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_found (res_found),
    .res_nonce (res_nonce),
    .res_ready (res_ready),
    .tx_busy   (tx_busy),
    .send      (send),
    .tx_data   (tx_data)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (send) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  assign tx_busy = hold_busy | (bcnt != 0);

  initial begin
    viol = 0;
    prev_send = 1'b0;
    for (int c = 0; c < 4; c++) rdy_cnt[c] = 0;
  end

  always @(negedge clk) begin
    if (send) q.push_back(tx_data);
    if (send && tx_busy) viol++;
    if (send && prev_send) viol++;
    if ($countones(res_ready) > 1) viol++;
    prev_send = send;
    for (int c = 0; c < 4; c++) begin
      if (res_ready[c]) begin
        rdy_cnt[c]++;
        gq.push_back(c);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(input int ch, input bit f,
                         input logic [63:0] n, input bit lat);
    int t;
    int prev;
    prev = rdy_cnt[ch];
    @(posedge clk);
    #1;
    res_valid = '0;
    res_valid[ch] = 1'b1;
    res_found[ch] = f;
    res_nonce[ch*64 +: 64] = n;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!res_ready[ch] && t < 500);
    chk($sformatf("grant_ch%0d", ch), 64'(res_ready[ch]), 64'd1);
    @(posedge clk);
    #1;
    res_valid = '0;
    res_found = ~res_found;
    res_nonce = ~res_nonce;
    if (lat) begin
      @(negedge clk);
      chk("lat_c1", 64'(send), 64'd0);
      @(negedge clk);
      chk("lat_c2", 64'(send), 64'd1);
    end
    chk($sformatf("ready_once_ch%0d", ch), 64'(rdy_cnt[ch]),
        64'(prev + 1));
  endtask

  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    chk("nbytes", 64'(q.size()), 64'(n));
  endtask

  task automatic serve_set(input logic [3:0] set);
    int t;
    logic [3:0] g;
    @(posedge clk);
    #1;
    res_valid = set;
    res_found = '0;
    t = 0;
    while (res_valid != 0 && t < 3000) begin
      @(negedge clk);
      g = res_ready;
      @(posedge clk);
      #1;
      res_valid = res_valid & ~g;
      t++;
    end
    chk("serve_done", 64'(res_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [7:0] cs;
    logic [7:0] eb;
    int sends;
    n_assert = 0;
    n_fail = 0;
    hold_busy = 1'b0;

    vt[0] = '{0, 1'b1, 64'h0123456789ABCDEF, 10,
              80'h0123456789ABCDEF80A5};
    vt[1] = '{2, 1'b0, 64'hDEADBEEFDEADBEEF, 2, 80'h02A5};
    vt[2] = '{3, 1'b1, 64'h00000000000000FF, 10,
              80'h00000000000000FF83A5};
    vt[3] = '{1, 1'b1, 64'hFFEEDDCCBBAA9988, 10,
              80'hFFEEDDCCBBAA998881A5};

    rst = 1'b1;
    res_valid = '1;
    res_found = '0;
    res_nonce = '0;
    repeat (2) @(negedge clk);
    chk("rst_send", 64'(send), 64'd0);
    chk("rst_txdata", 64'(tx_data), 64'h00);
    chk("rst_ready", 64'(res_ready), 64'd0);
    rst = 1'b0;
    res_valid = '0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      q.delete();
      capture(vt[v].ch, vt[v].found, vt[v].nonce, 1'b1);
      n = vt[v].n + XB;
      wait_bytes(n);
      cs = 8'h00;
      for (int k = 0; k < vt[v].n; k++) begin
        eb = vt[v].bytes[k*8 +: 8];
        if (k > 0) cs = cs ^ eb;
        if (k < q.size())
          chk($sformatf("v%0d_b%0d", v, k), 64'(q[k]), 64'(eb));
      end
      if (XB == 1 && q.size() == n)
        chk($sformatf("v%0d_csum", v), 64'(q[n-1]), 64'(cs));
      chk($sformatf("v%0d_idle_tx", v), 64'(tx_data), 64'h00);
    end

    q.delete();
    capture(0, 1'b0, 64'h0, 1'b1);
    wait_bytes(2 + XB);
    q.delete();
    gq.delete();
    serve_set(4'b1010);
    wait_bytes(2 * (2 + XB));
    chk("rr_a_cnt", 64'(gq.size()), 64'd2);
    if (gq.size() == 2) begin
      chk("rr_a_first", 64'(gq[0]), 64'd1);
      chk("rr_a_second", 64'(gq[1]), 64'd3);
    end
    if (q.size() == 2 * (2 + XB)) begin
      chk("rr_a_hdr1", 64'(q[1]), 64'h01);
      chk("rr_a_hdr2", 64'(q[2 + XB + 1]), 64'h03);
    end
    q.delete();
    gq.delete();
    serve_set(4'b1001);
    wait_bytes(2 * (2 + XB));
    if (gq.size() == 2) begin
      chk("rr_b_first", 64'(gq[0]), 64'd0);
      chk("rr_b_second", 64'(gq[1]), 64'd3);
    end else begin
      chk("rr_b_cnt", 64'(gq.size()), 64'd2);
    end

    q.delete();
    capture(0, 1'b1, 64'h1122334455667788, 1'b1);
    begin
      int t;
      t = 0;
      while (q.size() < 5 && t < 2000) begin
        @(negedge clk);
        t++;
      end
    end
    chk("mid_bytes", 64'(q.size()), 64'd5);
    rst = 1'b1;
    res_valid = 4'b0100;
    @(negedge clk);
    chk("mid_rst_send", 64'(send), 64'd0);
    chk("mid_rst_tx", 64'(tx_data), 64'h00);
    chk("mid_rst_ready", 64'(res_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    res_valid = '0;
    repeat (40) @(negedge clk);
    chk("abort_no_send", 64'(q.size()), 64'd5);
    q.delete();
    gq.delete();
    serve_set(4'b0011);
    wait_bytes(2 * (2 + XB));
    if (gq.size() > 0) chk("post_rst_rr", 64'(gq[0]), 64'd0);
    else chk("post_rst_grant", 64'(gq.size()), 64'd2);
    if (q.size() > 1) chk("post_rst_hdr", 64'(q[1]), 64'h00);

    q.delete();
    hold_busy = 1'b1;
    capture(2, 1'b0, 64'h0, 1'b0);
    sends = 0;
    repeat (50) begin
      @(negedge clk);
      if (send) sends++;
    end
    chk("busy_hold_nosend", 64'(sends), 64'd0);
    hold_busy = 1'b0;
    wait_bytes(2 + XB);
    if (q.size() > 1) chk("busy_hdr", 64'(q[1]), 64'h02);

`ifdef RESULT_PKT_CSUM_EN
    q.delete();
    capture(0, 1'b1, 64'h1, 1'b1);
    wait_bytes(11);
    if (q.size() == 11) chk("csum_81", 64'(q[10]), 64'h81);
`endif

    chk("protocol_viol", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
